// File: rtl/lap_memory_reader.sv
// Read-side sequencer for the lap-time BRAM: walks a block of addresses, hides the
// one-cycle BRAM read latency and streams words out over valid/ready with backpressure.
module lap_memory_reader #(
   parameter int RAM_WIDTH     = 16,
   parameter int RAM_ADDR_BITS = 9
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_start,
   input  logic [RAM_ADDR_BITS-1:0] i_base_addr,
   input  logic [RAM_ADDR_BITS:0]   i_count,
   output logic [RAM_ADDR_BITS-1:0] o_rd_addr,
   input  logic [RAM_WIDTH-1:0]     i_rd_data,
   output logic [RAM_WIDTH-1:0]     o_out_data,
   output logic                     o_out_valid,
   input  logic                     i_out_ready,
   output logic                     o_busy,
   output logic                     o_done
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

   localparam logic [RAM_ADDR_BITS:0]   CNT_ONE  = 1;
   localparam logic [RAM_ADDR_BITS-1:0] ADDR_ONE = 1;

   state_t                   r_state, w_state_nxt;
   logic [RAM_ADDR_BITS-1:0] r_addr;
   logic [RAM_ADDR_BITS:0]   r_issue_rem, r_accept_rem;
   logic                     r_in_flight, r_done;
   logic [RAM_WIDTH-1:0]     r_head, r_skid;
   logic                     r_head_vld, r_skid_vld;
   logic                     w_pop, w_issue, w_credit, w_last_accept, w_done_nxt;
   logic [1:0]               w_load;

   // The address register is what the BRAM samples; an issue is the edge where it
   // is consumed, so the returned word is pushed exactly one edge later.
   assign w_pop         = r_head_vld & i_out_ready;
   assign w_load        = {1'b0, r_head_vld} + {1'b0, r_skid_vld} + {1'b0, r_in_flight};
   assign w_credit      = (w_load <= (2'd1 + {1'b0, w_pop}));
   assign w_issue       = (r_state == S_READ) && (r_issue_rem != '0) && w_credit;
   assign w_last_accept = w_pop && (r_accept_rem == CNT_ONE);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_done_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start && (i_count != '0)) w_state_nxt = S_READ;
            else if (i_start)               w_done_nxt  = 1'b1;
         end
         S_READ: begin
            if (w_issue && (r_issue_rem == CNT_ONE)) w_state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (w_last_accept) begin
               w_state_nxt = S_IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_addr       <= '0;
         r_issue_rem  <= '0;
         r_accept_rem <= '0;
         r_in_flight  <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_done      <= w_done_nxt;
         r_in_flight <= w_issue;
         if ((r_state == S_IDLE) && i_start) begin
            r_addr       <= i_base_addr;
            r_issue_rem  <= i_count;
            r_accept_rem <= i_count;
         end else begin
            if (w_issue) begin
               r_issue_rem <= r_issue_rem - CNT_ONE;
               // hold the final address so rd_addr keeps the last issued value
               if (r_issue_rem != CNT_ONE) r_addr <= r_addr + ADDR_ONE;
            end
            if (w_pop) r_accept_rem <= r_accept_rem - CNT_ONE;
         end
      end
   end

   // Two-entry latency buffer: head register feeds the output, skid catches the
   // one word still returning from the BRAM when the consumer stalls.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_head     <= '0;
         r_skid     <= '0;
         r_head_vld <= 1'b0;
         r_skid_vld <= 1'b0;
      end else if (w_pop) begin
         if (r_skid_vld) begin
            r_head <= r_skid;
            if (r_in_flight) r_skid <= i_rd_data;
            else             r_skid_vld <= 1'b0;
         end else if (r_in_flight) begin
            r_head <= i_rd_data;
         end else begin
            r_head_vld <= 1'b0;
         end
      end else if (r_in_flight) begin
         if (!r_head_vld) begin
            r_head     <= i_rd_data;
            r_head_vld <= 1'b1;
         end else begin
            r_skid     <= i_rd_data;
            r_skid_vld <= 1'b1;
         end
      end
   end

   assign o_rd_addr   = r_addr;
   assign o_out_data  = r_head;
   assign o_out_valid = r_head_vld;
   assign o_busy      = (r_state != S_IDLE);
   assign o_done      = r_done;

endmodule
